// File: rtl/cla_request_arbiter.sv
// -----------------------------------------------------------------------------
// cla_request_arbiter
//
// Purpose:
//   Round-robin bus master that shares one memory-mapped carry-lookahead adder
//   peripheral between NUM_REQ requesters. One operand pair is accepted at a
//   time. The peripheral's active-low CS/WR/RD bus is then sequenced as:
//   write op A, write op B, read strobe, capture. The sum is returned only to
//   the requester that was granted.
//
// Parameters:
//   DATA_WIDTH  operand/result width (must match the adder peripheral)
//   ADD_WIDTH   peripheral address width
//   NUM_REQ     number of requesters (2..8)
//
// Ports:
//   clock        system clock, rising-edge logic
//   reset        synchronous active-low reset
//   req_valid    per-requester request, held with operands until req_ready
//   req_ready    one-hot accept, combinational in IDLE only
//   req_op_a     flattened op A, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_op_b     flattened op B, same slicing
//   rsp_valid    one-hot single-cycle result strobe to the owning requester
//   rsp_data     captured sum, holds between strobes
//   busy         high whenever the sequencer is not IDLE
//   cla_CS       peripheral chip select, active low
//   cla_WR       peripheral write strobe, active low
//   cla_RD       peripheral read strobe, active low
//   cla_Address  peripheral address (0 = op A, 1 = op B / result)
//   cla_Data     peripheral write data
//   cla_result   peripheral registered result
// -----------------------------------------------------------------------------
module cla_request_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADD_WIDTH  = 1,
    parameter int NUM_REQ    = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op_b,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          busy,
    output logic                          cla_CS,
    output logic                          cla_WR,
    output logic                          cla_RD,
    output logic [ADD_WIDTH-1:0]          cla_Address,
    output logic [DATA_WIDTH-1:0]         cla_Data,
    input  logic [DATA_WIDTH-1:0]         cla_result
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR_A = 3'd1,
        S_WR_B = 3'd2,
        S_RD   = 3'd3,
        S_CAP  = 3'd4
    } state_t;

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   op_a_q;
    logic [DATA_WIDTH-1:0]   op_b_q;
    logic [IDX_W-1:0]        grant_q;
    logic [IDX_W-1:0]        ptr_q;
    logic [NUM_REQ-1:0]      rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_data_q;

    logic                    found;
    logic [IDX_W-1:0]        win_idx;
    logic [IDX_W-1:0]        cand_idx;
    logic [DATA_WIDTH-1:0]   win_op_a;
    logic [DATA_WIDTH-1:0]   win_op_b;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin search: start just after the last winner and wrap, so the
    // most recently served requester has the lowest priority next time.
    always_comb begin
        found    = 1'b0;
        win_idx  = '0;
        cand_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_idx = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && req_valid[cand_idx]) begin
                found   = 1'b1;
                win_idx = cand_idx;
            end
        end
    end

    // Operand mux for the current winner.
    always_comb begin
        win_op_a = '0;
        win_op_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                win_op_a = req_op_a[i*DATA_WIDTH +: DATA_WIDTH];
                win_op_b = req_op_b[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Accept is combinational so a requester can be taken in the same cycle it
    // raises valid, including the cycle in which a previous result is strobed.
    assign req_ready = (state_q == S_IDLE && found) ? onehot(win_idx) : '0;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            grant_q     <= '0;
            ptr_q       <= IDX_W'(NUM_REQ - 1);
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            // Result strobe lasts exactly one cycle.
            rsp_valid_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (found) begin
                        op_a_q  <= win_op_a;
                        op_b_q  <= win_op_b;
                        grant_q <= win_idx;
                        ptr_q   <= win_idx;
                        state_q <= S_WR_A;
                    end
                end
                S_WR_A: state_q <= S_WR_B;
                S_WR_B: state_q <= S_RD;
                // The peripheral registers its sum at the end of RD, so the
                // value on cla_result is stable throughout CAP.
                S_RD:   state_q <= S_CAP;
                S_CAP: begin
                    rsp_data_q  <= cla_result;
                    rsp_valid_q <= onehot(grant_q);
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Moore bus decode straight from the state register. The strobes depend
    // only on flopped state, and WR and RD are never low together.
    always_comb begin
        cla_CS      = 1'b1;
        cla_WR      = 1'b1;
        cla_RD      = 1'b1;
        cla_Address = '0;
        cla_Data    = '0;
        case (state_q)
            S_WR_A: begin
                cla_CS   = 1'b0;
                cla_WR   = 1'b0;
                cla_Data = op_a_q;
            end
            S_WR_B: begin
                cla_CS      = 1'b0;
                cla_WR      = 1'b0;
                cla_Address = ADD_WIDTH'(1);
                cla_Data    = op_b_q;
            end
            S_RD: begin
                cla_CS      = 1'b0;
                cla_RD      = 1'b0;
                cla_Address = ADD_WIDTH'(1);
            end
            default: begin
                cla_CS = 1'b1;
            end
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_cla_request_arbiter.sv
module tb_cla_request_arbiter;

    localparam int DW = 32;
    localparam int AW = 1;
    localparam int NR = 4;

    logic              clock;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*DW-1:0]  req_op_a;
    logic [NR*DW-1:0]  req_op_b;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic              busy;
    logic              cla_CS;
    logic              cla_WR;
    logic              cla_RD;
    logic [AW-1:0]     cla_Address;
    logic [DW-1:0]     cla_Data;
    logic [DW-1:0]     cla_result;

    int tests;
    int fails;
    int proto_err;

    cla_request_arbiter #(.DATA_WIDTH(DW), .ADD_WIDTH(AW), .NUM_REQ(NR)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op_a    (req_op_a),
        .req_op_b    (req_op_b),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .busy        (busy),
        .cla_CS      (cla_CS),
        .cla_WR      (cla_WR),
        .cla_RD      (cla_RD),
        .cla_Address (cla_Address),
        .cla_Data    (cla_Data),
        .cla_result  (cla_result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Adder slave: op A at address 0, op B at address 1, sum registered on RD.
    logic [DW-1:0] slv_a;
    logic [DW-1:0] slv_b;
    initial begin
        slv_a      = '0;
        slv_b      = '0;
        cla_result = '0;
    end
    always @(posedge clock) begin
        if (!cla_CS && !cla_WR) begin
            if (cla_Address == 1'b0) slv_a <= cla_Data;
            else                     slv_b <= cla_Data;
        end
        if (!cla_CS && !cla_RD) cla_result <= slv_a + slv_b;
    end

    // Bus protocol and one-hot watch over the whole run.
    initial proto_err = 0;
    always @(negedge clock) begin
        if (!cla_WR && !cla_RD) proto_err = proto_err + 1;
        if (cla_WR && cla_RD && !cla_CS) proto_err = proto_err + 1;
        if ($countones(req_ready) > 1) proto_err = proto_err + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests = tests + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ops(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_op_a[idx*DW +: DW] = a;
        req_op_b[idx*DW +: DW] = b;
    endtask

    // One isolated transaction from requester idx; ends in the rsp_valid cycle.
    task automatic txn(input string tag, input int idx, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [DW-1:0] sum);
        logic [NR-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        set_ops(idx, a, b);
        req_valid = oh;
        #1;
        check({tag, "_ready"}, 64'(req_ready), 64'(oh));
        tick();
        req_valid = '0;
        repeat (4) tick();
        check({tag, "_rspv"}, 64'(rsp_valid), 64'(oh));
        check({tag, "_rspd"}, 64'(rsp_data), 64'(sum));
    endtask

    logic [DW-1:0] fair_sum [NR];
    logic [NR-1:0] fexp;

    initial begin
        tests     = 0;
        fails     = 0;
        reset     = 1'b0;
        req_valid = '0;
        req_op_a  = '0;
        req_op_b  = '0;
        fair_sum[0] = 32'h0000_0101;
        fair_sum[1] = 32'h0000_0211;
        fair_sum[2] = 32'h0000_0321;
        fair_sum[3] = 32'h0000_0431;

        // Reset state
        tick();
        tick();
        check("rst_ready", 64'(req_ready), 64'h0);
        check("rst_rspv",  64'(rsp_valid), 64'h0);
        check("rst_busy",  64'(busy),      64'h0);
        check("rst_rspd",  64'(rsp_data),  64'h0);
        check("rst_bus",   64'({cla_CS, cla_WR, cla_RD}), 64'h7);
        check("rst_addr",  64'(cla_Address), 64'h0);
        check("rst_data",  64'(cla_Data),  64'h0);
        reset = 1'b1;
        tick();

        // Single request with full bus sequence
        set_ops(0, 32'h5, 32'h7);
        req_valid = 4'b0001;
        #1;
        check("s_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0;
        check("s_busy",   64'(busy), 64'h1);
        check("s_ready0", 64'(req_ready), 64'h0);
        check("s_wra",    64'({cla_CS, cla_WR, cla_RD, cla_Address, cla_Data}), 64'({4'b0010, 32'h5}));
        tick();
        check("s_wrb",    64'({cla_CS, cla_WR, cla_RD, cla_Address, cla_Data}), 64'({4'b0011, 32'h7}));
        tick();
        check("s_rd",     64'({cla_CS, cla_WR, cla_RD, cla_Address, cla_Data}), 64'({4'b0101, 32'h0}));
        tick();
        check("s_cap",    64'({cla_CS, cla_WR, cla_RD}), 64'h7);
        check("s_cap_rv", 64'(rsp_valid), 64'h0);
        tick();
        check("s_rspv",   64'(rsp_valid), 64'h1);
        check("s_rspd",   64'(rsp_data), 64'hC);
        check("s_idle",   64'(busy), 64'h0);
        tick();
        check("s_rspv0",  64'(rsp_valid), 64'h0);
        check("s_hold",   64'(rsp_data), 64'hC);

        // Modulo wrap, carry discarded
        txn("wrap1", 2, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
        tick();
        txn("wrap2", 2, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000);
        tick();

        // Contention after reset: req0 then req3, handed over back-to-back
        reset = 1'b0;
        tick();
        reset = 1'b1;
        set_ops(0, 32'd1, 32'd2);
        set_ops(3, 32'd10, 32'd20);
        req_valid = 4'b1001;
        #1;
        check("c_ready0", 64'(req_ready), 64'h1);
        tick();
        req_valid = 4'b1000;
        repeat (4) tick();
        check("c_rspv0",  64'(rsp_valid), 64'h1);
        check("c_rspd0",  64'(rsp_data), 64'h3);
        check("c_ready3", 64'(req_ready), 64'h8);
        tick();
        req_valid = '0;
        repeat (4) tick();
        check("c_rspv3",  64'(rsp_valid), 64'h8);
        check("c_rspd3",  64'(rsp_data), 64'h1E);
        tick();

        // Fairness: all four held valid for 20 transactions
        for (int i = 0; i < NR; i++) set_ops(i, DW'(i * 16 + 1), DW'(256 * (i + 1)));
        req_valid = 4'b1111;
        #1;
        for (int t = 0; t < 20; t++) begin
            fexp = '0;
            fexp[t % NR] = 1'b1;
            check("f_ready", 64'(req_ready), 64'(fexp));
            tick();
            repeat (4) tick();
            check("f_rspv", 64'(rsp_valid), 64'(fexp));
            check("f_rspd", 64'(rsp_data), 64'(fair_sum[t % NR]));
        end
        req_valid = '0;
        #1;
        check("f_drop", 64'(req_ready), 64'h0);
        tick();

        // Reset in WR_B of a req1 transaction
        set_ops(1, 32'h55, 32'h66);
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        tick();
        check("r_inwrb", 64'({cla_WR, cla_Address}), 64'h1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("r_bus",  64'({cla_CS, cla_WR, cla_RD}), 64'h7);
        check("r_busy", 64'(busy), 64'h0);
        check("r_rspv", 64'(rsp_valid), 64'h0);
        repeat (4) tick();
        check("r_norsp", 64'(rsp_valid), 64'h0);
        set_ops(0, 32'h1234_5678, 32'h1111_1111);
        req_valid = 4'b1001;
        #1;
        check("r_prio", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0;
        repeat (4) tick();
        check("r_rspv0", 64'(rsp_valid), 64'h1);
        check("r_rspd0", 64'(rsp_data), 64'h2345_6789);
        tick();

        // Back-to-back on req1
        txn("bb1", 1, 32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000);
        set_ops(1, 32'd100, 32'd200);
        req_valid = 4'b0010;
        #1;
        check("bb_ready", 64'(req_ready), 64'h2);
        check("bb_busy0", 64'(busy), 64'h0);
        tick();
        req_valid = '0;
        check("bb_busy1", 64'(busy), 64'h1);
        repeat (4) tick();
        check("bb_rspv", 64'(rsp_valid), 64'h2);
        check("bb_rspd", 64'(rsp_data), 64'h12C);
        tick();
        check("bb_hold", 64'(rsp_data), 64'h12C);

        check("protocol", 64'(proto_err), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cla_request_arbiter.md
Name: cla_request_arbiter

Overview:
- Round-robin bus master that shares the memory-mapped 32-bit carry-lookahead adder peripheral between NUM_REQ independent requesters.
- Accepts an operand pair from one requester at a time and sequences the peripheral's active-low CS/WR/RD bus: write op A, write op B, read strobe, capture.
- Returns the sum to the granted requester only.
- Sits between compute clients and the adder slave, in the same clock domain.

Parameters:
- DATA_WIDTH, 32, operand/result width; must match the adder peripheral.
- ADD_WIDTH, 1, peripheral address width.
- NUM_REQ, 4, number of requesters (2..8).

Ports:
- clock  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (sampled on rising edge of clock).
- req_valid  in  NUM_REQ  per-requester request; held with operands until req_ready.
- req_ready  out  NUM_REQ  one-hot accept; a transfer occurs when req_valid[i]&req_ready[i] are high at an edge.
- req_op_a  in  NUM_REQ*DATA_WIDTH  flattened op A; requester i uses [i*DATA_WIDTH +: DATA_WIDTH].
- req_op_b  in  NUM_REQ*DATA_WIDTH  flattened op B, same slicing.
- rsp_valid  out  NUM_REQ  one-hot, single-cycle result strobe to the owning requester.
- rsp_data  out  DATA_WIDTH  sum; valid when any rsp_valid bit is high, holds value otherwise.
- busy  out  1  high whenever FSM is not IDLE.
- cla_CS  out  1  peripheral chip select, active low.
- cla_WR  out  1  peripheral write strobe, active low.
- cla_RD  out  1  peripheral read strobe, active low.
- cla_Address  out  ADD_WIDTH  peripheral address.
- cla_Data  out  DATA_WIDTH  peripheral write data.
- cla_result  in  DATA_WIDTH  peripheral registered result (o_result).

Behaviour:
- Reset (reset low at an edge):
  - FSM goes to IDLE.
  - req_ready, rsp_valid, busy = 0; rsp_data = 0.
  - Bus idle: cla_CS = cla_WR = cla_RD = 1, cla_Address = 0, cla_Data = 0.
  - Operand registers = 0; grant index = 0.
  - Round-robin pointer = NUM_REQ-1, so req0 has highest priority first.
  - Reset mid-transaction aborts it with no rsp_valid; the requester must re-issue.
- States: IDLE -> WR_A -> WR_B -> RD -> CAP -> IDLE. Moore bus outputs decoded from the state register, no glitches.
- IDLE:
  - Bus idle.
  - If any req_valid: pick the first set bit searching from (pointer+1) mod NUM_REQ upward with wrap, and assert req_ready for that bit only, combinationally, in the same cycle.
  - At the edge: latch op A/op B of the winner, store the grant index, set pointer = winner, go to WR_A.
  - No req_valid: stay, req_ready = 0.
- WR_A: CS=0, WR=0, RD=1, Address=0, Data=opA.
- WR_B: CS=0, WR=0, RD=1, Address=1, Data=opB.
- RD: CS=0, WR=1, RD=0, Address=1, Data=0. The peripheral registers the sum at this edge.
- CAP: bus idle. At the edge: rsp_data <= cla_result, rsp_valid <= onehot(grant index), go to IDLE.
- rsp_valid is high exactly one cycle, the first IDLE cycle after CAP. A new request may be accepted in that same cycle.
- Latency: acceptance edge E; WR_A, WR_B, RD, CAP in cycles E+1..E+4; rsp_valid in cycle E+5.
- Throughput: one transaction per 5 cycles.
- Arithmetic: modulo 2^DATA_WIDTH, carry-out discarded (e.g. 0xFFFFFFFF + 1 = 0x00000000).
- Fairness: under continuous requests from all NUM_REQ requesters, grants rotate 0,1,...,NUM_REQ-1,0,...
- A requester dropping req_valid before ready is legal; it is simply not granted, with no side effects.
- req_valid/operands of non-granted requesters are ignored while busy. req_ready = 0 outside IDLE.
- Never assert cla_WR and cla_RD low simultaneously. cla_CS is high whenever both strobes are high.

Test Plan:
- Single request: req0 A=0x00000005, B=0x00000007 -> bus sequence WR_A(addr0, 5), WR_B(addr1, 7), RD(addr1); rsp_valid=0001 and rsp_data=0x0000000C exactly 5 cycles after acceptance.
- Wrap: req2 A=0xFFFFFFFF, B=0x00000001 -> rsp_valid=0100, rsp_data=0x00000000; A=0x80000000, B=0x80000000 -> 0x00000000.
- Contention: req0 (1+2) and req3 (10+20) raised together after reset -> req0 served first (rsp 0x3 on bit0), then req3 (rsp 0x1E on bit3); req_ready never two-hot.
- Fairness: all four held valid for 20 transactions -> grant order 0,1,2,3 repeating; each rsp routed to the correct one-hot bit with the correct sum.
- Reset mid-op: reset low for 1 edge during WR_B -> next cycle bus idle, busy=0, no rsp_valid; a re-issued request completes correctly and req0 again has priority.
- Back-to-back: req1 re-asserted in the rsp_valid cycle -> accepted that cycle; busy stays low for only that one cycle; a bus-protocol checker sees no WR/RD overlap throughout.
